// File: rtl/aplic_msi_sender.sv
// MSI transmit path of the APLIC: round-robin arbitration over domain requests,
// hart-index range validation, and one 32-bit write per accepted request.
module aplic_msi_sender #(
    parameter int numDomains = 4,
    parameter int numRanges  = 10
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [numDomains-1:0]      req_valid,
    output logic [numDomains-1:0]      req_ready,
    input  logic [numDomains*14-1:0]   req_hartIndex,
    input  logic [numDomains*11-1:0]   req_EIID,
    input  logic [numDomains*44-1:0]   cfg_basePPN,
    input  logic [numRanges*14-1:0]    cfg_rangeFirst,
    input  logic [numRanges*14-1:0]    cfg_rangeLast,
    input  logic [numRanges-1:0]       cfg_rangeEnable,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic [55:0]                wr_addr,
    output logic [31:0]                wr_data,
    input  logic                       wr_respValid,
    input  logic                       wr_respErr,
    output logic [numDomains-1:0]      dropPulse,
    output logic [numDomains-1:0]      errPulse,
    output logic                       busy
);

    localparam int IW = (numDomains > 1) ? $clog2(numDomains) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        SEND      = 2'd2,
        WAIT_RESP = 2'd3
    } state_t;

    state_t                 state_r;
    logic [IW-1:0]          rr_ptr_r;
    logic [IW-1:0]          dom_r;
    logic [13:0]            hart_r;
    logic [10:0]            eiid_r;
    logic [43:0]            base_ppn_r;
    logic                   wr_valid_r;
    logic [55:0]            wr_addr_r;
    logic [31:0]            wr_data_r;
    logic [numDomains-1:0]  drop_pulse_r;
    logic [numDomains-1:0]  err_pulse_r;
    logic                   busy_r;

    logic [numDomains-1:0]  grant_s;
    logic [IW-1:0]          grant_idx_s;
    logic                   grant_any_s;
    logic                   hit_s;
    logic [43:0]            ppn_sum_s;

    // Round-robin search starting at rr_ptr_r, first requester wins.
    always_comb begin
        int  idx_v;
        logic take_v;
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        grant_s     = '0;
        idx_v       = 0;
        take_v      = 1'b0;
        for (int i = 0; i < numDomains; i++) begin
            idx_v       = (int'(rr_ptr_r) + i) % numDomains;
            take_v      = !grant_any_s && req_valid[IW'(idx_v)];
            grant_idx_s = take_v ? IW'(idx_v) : grant_idx_s;
            grant_any_s = grant_any_s | take_v;
        end
        for (int d = 0; d < numDomains; d++) begin
            grant_s[d] = grant_any_s && (grant_idx_s == IW'(d));
        end
    end

    // Hart-index validation against enabled inclusive ranges; first > last never matches.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < numRanges; i++) begin
            hit_s = hit_s | (cfg_rangeEnable[i]
                             && (cfg_rangeFirst[i*14 +: 14] <= hart_r)
                             && (hart_r <= cfg_rangeLast[i*14 +: 14]));
        end
    end

    assign ppn_sum_s = base_ppn_r + {30'd0, hart_r};

    // Grants are visible only in IDLE and never while reset is held.
    assign req_ready = ((state_r == IDLE) && !reset) ? grant_s : '0;

    assign wr_valid  = wr_valid_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign dropPulse = drop_pulse_r;
    assign errPulse  = err_pulse_r;
    assign busy      = busy_r;

    // Transaction FSM with registered bus outputs and one-cycle status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            rr_ptr_r     <= '0;
            dom_r        <= '0;
            hart_r       <= 14'd0;
            eiid_r       <= 11'd0;
            base_ppn_r   <= 44'd0;
            wr_valid_r   <= 1'b0;
            wr_addr_r    <= 56'd0;
            wr_data_r    <= 32'd0;
            drop_pulse_r <= '0;
            err_pulse_r  <= '0;
            busy_r       <= 1'b0;
        end else begin
            drop_pulse_r <= '0;
            err_pulse_r  <= '0;
            case (state_r)
                IDLE: begin
                    if (grant_any_s) begin
                        for (int d = 0; d < numDomains; d++) begin
                            if (grant_s[d]) begin
                                hart_r     <= req_hartIndex[d*14 +: 14];
                                eiid_r     <= req_EIID[d*11 +: 11];
                                base_ppn_r <= cfg_basePPN[d*44 +: 44];
                            end
                        end
                        dom_r    <= grant_idx_s;
                        rr_ptr_r <= (grant_idx_s == IW'(numDomains - 1)) ? '0 : grant_idx_s + IW'(1);
                        state_r  <= CHECK;
                        busy_r   <= 1'b1;
                    end
                end
                CHECK: begin
                    if (hit_s) begin
                        wr_addr_r  <= {ppn_sum_s, 12'h000};
                        wr_data_r  <= {21'd0, eiid_r};
                        wr_valid_r <= 1'b1;
                        state_r    <= SEND;
                    end else begin
                        drop_pulse_r[dom_r] <= 1'b1;
                        state_r             <= IDLE;
                        busy_r              <= 1'b0;
                    end
                end
                SEND: begin
                    if (wr_ready) begin
                        wr_valid_r <= 1'b0;
                        state_r    <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (wr_respValid) begin
                        err_pulse_r[dom_r] <= wr_respErr;
                        state_r            <= IDLE;
                        busy_r             <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    wr_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aplic_msi_sender.sv
// Directed bench for aplic_msi_sender: expected writes are queued when a request
// is granted and compared when the write appears on the bus.
module tb_aplic_msi_sender;

    localparam int ND = 4;
    localparam int NR = 10;

    logic                clock = 1'b0;
    logic                reset;
    logic [ND-1:0]       req_valid;
    logic [ND-1:0]       req_ready;
    logic [ND*14-1:0]    req_hartIndex;
    logic [ND*11-1:0]    req_EIID;
    logic [ND*44-1:0]    cfg_basePPN;
    logic [NR*14-1:0]    cfg_rangeFirst;
    logic [NR*14-1:0]    cfg_rangeLast;
    logic [NR-1:0]       cfg_rangeEnable;
    logic                wr_valid;
    logic                wr_ready;
    logic [55:0]         wr_addr;
    logic [31:0]         wr_data;
    logic                wr_respValid;
    logic                wr_respErr;
    logic [ND-1:0]       dropPulse;
    logic [ND-1:0]       errPulse;
    logic                busy;

    typedef struct packed {
        logic [55:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [13:0] m_hart [ND];
    logic [10:0] m_eiid [ND];
    logic [43:0] m_base [ND];
    int          checks = 0;
    int          errors = 0;

    aplic_msi_sender #(.numDomains(ND), .numRanges(NR)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_hartIndex(req_hartIndex), .req_EIID(req_EIID),
        .cfg_basePPN(cfg_basePPN),
        .cfg_rangeFirst(cfg_rangeFirst), .cfg_rangeLast(cfg_rangeLast),
        .cfg_rangeEnable(cfg_rangeEnable),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_respValid(wr_respValid), .wr_respErr(wr_respErr),
        .dropPulse(dropPulse), .errPulse(errPulse), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_dom(input int d, input logic [13:0] h, input logic [10:0] e, input logic [43:0] b);
        m_hart[d] = h;
        m_eiid[d] = e;
        m_base[d] = b;
        req_hartIndex[d*14 +: 14] = h;
        req_EIID[d*11 +: 11]      = e;
        cfg_basePPN[d*44 +: 44]   = b;
    endtask

    task automatic set_range(input int i, input logic [13:0] f, input logic [13:0] l, input logic en);
        cfg_rangeFirst[i*14 +: 14] = f;
        cfg_rangeLast[i*14 +: 14]  = l;
        cfg_rangeEnable[i]         = en;
    endtask

    task automatic push_write(input int d);
        exp_t e;
        e.addr = {m_base[d] + {30'd0, m_hart[d]}, 12'h000};
        e.data = {21'd0, m_eiid[d]};
        sb.push_back(e);
    endtask

    task automatic wait_grant(input int d);
        int n = 0;
        #1;
        while (req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("grant_d%0d", d), 64'(req_ready), 64'(1) << d);
    endtask

    // Completes one write: waits for wr_valid, compares against the queue,
    // holds wr_ready low for ready_delay cycles, then returns a response.
    task automatic serve(input int ready_delay, input logic err, input int d);
        int   n = 0;
        exp_t e;
        while (wr_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("wr_valid_seen", 64'(wr_valid), 64'd1);
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", 64'(wr_data), 64'(e.data));
        for (int k = 0; k < ready_delay; k++) begin
            tick();
            chk("bp_valid", 64'(wr_valid), 64'd1);
            chk("bp_addr", 64'(wr_addr), 64'(e.addr));
            chk("bp_data", 64'(wr_data), 64'(e.data));
        end
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        chk("valid_after_accept", 64'(wr_valid), 64'd0);
        chk("busy_wait_resp", 64'(busy), 64'd1);
        wr_respValid = 1'b1;
        wr_respErr   = err;
        tick();
        wr_respValid = 1'b0;
        wr_respErr   = 1'b0;
        chk("err_pulse", 64'(errPulse), err ? (64'(1) << d) : 64'd0);
        chk("busy_after_resp", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_hartIndex = '0;
        req_EIID = '0;
        cfg_basePPN = '0;
        cfg_rangeFirst = '0;
        cfg_rangeLast = '0;
        cfg_rangeEnable = '0;
        wr_ready = 1'b0;
        wr_respValid = 1'b0;
        wr_respErr = 1'b0;
        for (int d = 0; d < ND; d++) set_dom(d, 14'd0, 11'd0, 44'd0);
        tick();
        tick();
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_addr", 64'(wr_addr), 64'd0);
        chk("rst_data", 64'(wr_data), 64'd0);
        chk("rst_drop", 64'(dropPulse), 64'd0);
        chk("rst_err", 64'(errPulse), 64'd0);
        reset = 1'b0;
        tick();

        // Single write, domain 0
        set_range(0, 14'd0, 14'd9, 1'b1);
        set_dom(0, 14'd5, 11'h123, 44'h1000);
        req_valid = 4'b0001;
        wait_grant(0);
        push_write(0);
        tick();
        req_valid = '0;
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_valid_check", 64'(wr_valid), 64'd0);
        tick();
        chk("t1_valid_T2", 64'(wr_valid), 64'd1);
        chk("t1_addr_const", 64'(wr_addr), 64'h0000_0100_5000);
        chk("t1_data_const", 64'(wr_data), 64'h0000_0123);
        chk("t1_no_drop", 64'(dropPulse), 64'd0);
        serve(0, 1'b0, 0);

        // Invalid hart index: outside [0,9] and [30,40]
        set_range(1, 14'd30, 14'd40, 1'b1);
        set_dom(0, 14'd20, 11'h1, 44'h2000);
        req_valid = 4'b0001;
        wait_grant(0);
        tick();
        req_valid = '0;
        tick();
        chk("drop1_pulse", 64'(dropPulse), 64'h1);
        chk("drop1_valid", 64'(wr_valid), 64'd0);
        chk("drop1_busy", 64'(busy), 64'd0);
        tick();
        chk("drop1_clear", 64'(dropPulse), 64'd0);

        // Inverted range first=12 > last=8 never matches
        set_range(0, 14'd12, 14'd8, 1'b1);
        set_range(1, 14'd0, 14'd0, 1'b0);
        set_dom(0, 14'd10, 11'h2, 44'h2000);
        req_valid = 4'b0001;
        wait_grant(0);
        tick();
        req_valid = '0;
        tick();
        chk("drop2_pulse", 64'(dropPulse), 64'h1);
        chk("drop2_valid", 64'(wr_valid), 64'd0);
        tick();

        // Backpressure for 7 cycles then an error response
        set_range(0, 14'd0, 14'd9, 1'b1);
        set_dom(2, 14'd3, 11'h7FF, 44'hABC);
        req_valid = 4'b0100;
        wait_grant(2);
        push_write(2);
        tick();
        req_valid = '0;
        serve(7, 1'b1, 2);
        tick();
        chk("err_clear", 64'(errPulse), 64'd0);
        chk("err_idle", 64'(busy), 64'd0);

        // Top hart index exactly matching a single-point range
        set_range(0, 14'h3FFF, 14'h3FFF, 1'b1);
        set_dom(1, 14'h3FFF, 11'h1, 44'h5);
        req_valid = 4'b0010;
        wait_grant(1);
        push_write(1);
        tick();
        req_valid = '0;
        serve(0, 1'b0, 1);
        chk("max_hart_addr", 64'(wr_addr), 64'h4004000);

        // PPN sum wraps to zero
        set_range(0, 14'd0, 14'd9, 1'b1);
        set_dom(3, 14'd1, 11'h2, 44'hFFF_FFFF_FFFF);
        req_valid = 4'b1000;
        wait_grant(3);
        push_write(3);
        tick();
        req_valid = '0;
        serve(0, 1'b0, 3);
        chk("wrap_addr", 64'(wr_addr), 64'd0);

        // Round-robin from reset: 0,1,2,3,0,1 with all requesting
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int d = 0; d < ND; d++) set_dom(d, 14'd1, 11'(16 + d), 44'(256 * (d + 1)));
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_grant(k % ND);
            push_write(k % ND);
            tick();
            serve(0, 1'b0, k % ND);
        end
        // rr pointer now at 2, only domains 1 and 3 requesting
        req_valid = 4'b1010;
        wait_grant(3);
        push_write(3);
        tick();
        serve(0, 1'b0, 3);
        wait_grant(1);
        push_write(1);
        tick();
        req_valid = '0;
        serve(0, 1'b0, 1);

        // Reset while in SEND
        set_dom(0, 14'd4, 11'h55, 44'h20);
        req_valid = 4'b0001;
        wait_grant(0);
        tick();
        req_valid = '0;
        tick();
        chk("rs_valid_before", 64'(wr_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rs_valid_async", 64'(wr_valid), 64'd0);
        chk("rs_busy_async", 64'(busy), 64'd0);
        chk("rs_addr_async", 64'(wr_addr), 64'd0);
        chk("rs_pulses", 64'({dropPulse, errPulse}), 64'd0);
        tick();
        reset = 1'b0;
        wr_respValid = 1'b1;
        wr_respErr   = 1'b1;
        tick();
        wr_respValid = 1'b0;
        wr_respErr   = 1'b0;
        chk("stray_resp_err", 64'(errPulse), 64'd0);
        chk("stray_resp_busy", 64'(busy), 64'd0);
        req_valid = 4'b1111;
        wait_grant(0);
        push_write(0);
        tick();
        req_valid = '0;
        serve(0, 1'b0, 0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
